// File: rtl/calc_accum_unit_if.sv
// Command/result bundle for calc_accum_unit.
// Handshake: a command is offered by a rising edge on Enter (Enter high at a
// clock edge where it was low at the previous edge). It is accepted only when
// Busy is low at that edge. A rising edge seen while Busy is high is dropped,
// not queued. NumOut/Carry/Zero hold the accumulator state and are valid
// whenever Busy is low.
interface calc_accum_unit_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int RSW = $clog2(NUM_REGS);

  logic [WIDTH-1:0] NumIn;
  logic [3:0]       OpIn;
  logic [RSW-1:0]   RegSel;
  logic             Enter;
  logic [WIDTH-1:0] NumOut;
  logic             Carry;
  logic             Zero;
  logic             Busy;
  logic             dbg_state;  // 0 = IDLE, 1 = MUL_RUN

  modport master (
    output NumIn, OpIn, RegSel, Enter,
    input  NumOut, Carry, Zero, Busy, dbg_state
  );

  modport slave (
    input  NumIn, OpIn, RegSel, Enter,
    output NumOut, Carry, Zero, Busy, dbg_state
  );
endinterface

// File: rtl/calc_accum_unit.sv
// calc_accum_unit: parametrised accumulator calculator core with a scratch
// register file, status flags and a shift-add multiplier (one multiplier bit
// per cycle, Busy high while it runs).
// Optional macro CALC_UNDO_EN: adds a one-deep undo shadow for A/Carry/Zero,
// restored by opcode 15. Without it opcode 15 is a NOP.
module calc_accum_unit #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clock,
  input  logic              Reset,
  calc_accum_unit_if.slave  io_bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_OR     = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_EQ     = 4'd5;
  localparam logic [3:0] OP_SHL    = 4'd6;
  localparam logic [3:0] OP_SHR    = 4'd7;
  localparam logic [3:0] OP_LOAD   = 4'd8;
  localparam logic [3:0] OP_STORE  = 4'd9;
  localparam logic [3:0] OP_RECALL = 4'd10;
  localparam logic [3:0] OP_CLEAR  = 4'd11;
  localparam logic [3:0] OP_MUL    = 4'd12;
`ifdef CALC_UNDO_EN
  localparam logic [3:0] OP_UNDO   = 4'd15;
`endif

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_enter_q;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_zero;
  logic               r_busy;
  logic [WIDTH-1:0]   r_regs [NUM_REGS];
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
`ifdef CALC_UNDO_EN
  logic [WIDTH-1:0]   r_sh_acc;
  logic               r_sh_carry;
  logic               r_sh_zero;
  logic               r_sh_valid;
`endif

  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout;
  logic               w_wr;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_mul_done;

  // Rising Enter while idle is a command; Busy blocks acceptance.
  assign w_accept    = io_bus.Enter & ~r_enter_q & (r_state == S_IDLE);
  assign w_sum       = {1'b0, r_acc} + {1'b0, io_bus.NumIn};
  // MSB of the extended difference is the borrow (A < N).
  assign w_dif       = {1'b0, r_acc} - {1'b0, io_bus.NumIn};
  // Final partial product is folded in combinationally so the result lands
  // on the WIDTH-th edge after acceptance.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done  = (r_cnt == CW'(WIDTH - 1));

  // Single-cycle ALU result, carry and accumulator write enable.
  always_comb begin
    w_res  = r_acc;
    w_cout = 1'b0;
    w_wr   = 1'b0;
    case (io_bus.OpIn)
      OP_ADD:    begin w_res = w_sum[WIDTH-1:0]; w_cout = w_sum[WIDTH]; w_wr = 1'b1; end
      OP_SUB:    begin w_res = w_dif[WIDTH-1:0]; w_cout = w_dif[WIDTH]; w_wr = 1'b1; end
      OP_OR:     begin w_res = r_acc | io_bus.NumIn; w_wr = 1'b1; end
      OP_AND:    begin w_res = r_acc & io_bus.NumIn; w_wr = 1'b1; end
      OP_XOR:    begin w_res = r_acc ^ io_bus.NumIn; w_wr = 1'b1; end
      OP_EQ:     begin w_res = (r_acc == io_bus.NumIn) ? WIDTH'(1) : '0; w_wr = 1'b1; end
      OP_SHL:    begin w_res = {r_acc[WIDTH-2:0], 1'b0}; w_cout = r_acc[WIDTH-1]; w_wr = 1'b1; end
      OP_SHR:    begin w_res = {1'b0, r_acc[WIDTH-1:1]}; w_cout = r_acc[0]; w_wr = 1'b1; end
      OP_LOAD:   begin w_res = io_bus.NumIn; w_wr = 1'b1; end
      OP_RECALL: begin w_res = r_regs[io_bus.RegSel]; w_wr = 1'b1; end
      OP_CLEAR:  begin w_res = '0; w_wr = 1'b1; end
      default:   ;
    endcase
  end

  // Control FSM plus all datapath state; outputs are registered.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_enter_q <= 1'b1;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b1;
      r_busy    <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef CALC_UNDO_EN
      r_sh_acc   <= '0;
      r_sh_carry <= 1'b0;
      r_sh_zero  <= 1'b1;
      r_sh_valid <= 1'b0;
`endif
    end else begin
      r_enter_q <= io_bus.Enter;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef CALC_UNDO_EN
            if (w_wr || io_bus.OpIn == OP_MUL) begin
              r_sh_acc   <= r_acc;
              r_sh_carry <= r_carry;
              r_sh_zero  <= r_zero;
              r_sh_valid <= 1'b1;
            end
`endif
            if (io_bus.OpIn == OP_MUL) begin
              r_state  <= S_MUL_RUN;
              r_busy   <= 1'b1;
              r_mcand  <= {{WIDTH{1'b0}}, r_acc};
              r_mplier <= io_bus.NumIn;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else if (w_wr) begin
              r_acc   <= w_res;
              r_carry <= w_cout;
              r_zero  <= (w_res == '0);
            end else if (io_bus.OpIn == OP_STORE) begin
              r_regs[io_bus.RegSel] <= r_acc;
`ifdef CALC_UNDO_EN
            end else if (io_bus.OpIn == OP_UNDO && r_sh_valid) begin
              r_acc      <= r_sh_acc;
              r_carry    <= r_sh_carry;
              r_zero     <= r_sh_zero;
              r_sh_valid <= 1'b0;
`endif
            end
          end
        end
        S_MUL_RUN: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_acc   <= w_prod_next[WIDTH-1:0];
            r_carry <= |w_prod_next[2*WIDTH-1:WIDTH];
            r_zero  <= (w_prod_next[WIDTH-1:0] == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.NumOut    = r_acc;
  assign io_bus.Carry     = r_carry;
  assign io_bus.Zero      = r_zero;
  assign io_bus.Busy      = r_busy;
  assign io_bus.dbg_state = r_state;
endmodule

// File: tb/tb_calc_accum_unit.sv
// Bench for calc_accum_unit (WIDTH=8, NUM_REGS=4): directed plan followed by
// random commands, checked against an arithmetic reference model through an
// expected-result queue popped by an independent monitor.
module tb_calc_accum_unit;
  localparam int W    = 8;
  localparam int NR   = 4;
  localparam int MASK = (1 << W) - 1;

  logic clock = 1'b0;
  logic Reset = 1'b0;

  // Clock
  always #5 clock = ~clock;

  calc_accum_unit_if #(.WIDTH(W), .NUM_REGS(NR)) ifc ();

  calc_accum_unit #(.WIDTH(W), .NUM_REGS(NR)) dut (
    .clock  (clock),
    .Reset  (Reset),
    .io_bus (ifc)
  );

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];  // {carry, zero, acc}

  // Reference model state
  int m_acc;
  bit m_carry, m_zero;
  int m_regs[NR];
  int sh_acc;
  bit sh_c, sh_z, sh_v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0; m_carry = 0; m_zero = 1;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    sh_acc = 0; sh_c = 0; sh_z = 1; sh_v = 0;
  endfunction

  function automatic void model_apply(input int op, input int n, input int rs);
    int a, r;
    longint p;
    bit wr, c;
    a = m_acc; r = 0; wr = 1; c = 0;
    case (op)
      0:  begin r = a + n; c = (r > MASK); end
      1:  begin c = (a < n); r = a - n; end
      2:  r = a | n;
      3:  r = a & n;
      4:  r = a ^ n;
      5:  r = (a == n) ? 1 : 0;
      6:  begin c = ((a >> (W - 1)) & 1) != 0; r = a << 1; end
      7:  begin c = (a & 1) != 0; r = a >> 1; end
      8:  r = n;
      9:  begin m_regs[rs] = a; wr = 0; end
      10: r = m_regs[rs];
      11: r = 0;
      12: begin p = longint'(a) * longint'(n); c = (p >> W) != 0; r = int'(p & MASK); end
`ifdef CALC_UNDO_EN
      15: begin
        wr = 0;
        if (sh_v) begin
          m_acc = sh_acc; m_carry = sh_c; m_zero = sh_z; sh_v = 0;
        end
      end
`endif
      default: wr = 0;
    endcase
    if (wr) begin
      sh_acc = m_acc; sh_c = m_carry; sh_z = m_zero; sh_v = 1;
      m_acc = r & MASK;
      m_carry = c;
      m_zero = (m_acc == 0);
    end
  endfunction

  // Driver: one command as a single-cycle Enter pulse; MUL waits out Busy.
  task automatic cmd(input int op, input int n, input int rs, input bit pulse);
    logic [31:0] t;
    @(negedge clock);
    t = op;  ifc.OpIn   = t[3:0];
    t = n;   ifc.NumIn  = t[W-1:0];
    t = rs;  ifc.RegSel = t[1:0];
    ifc.Enter = 1'b1;
    model_apply(op, n, rs);
    exp_q.push_back({m_carry, m_zero, m_acc[W-1:0]});
    @(negedge clock);
    ifc.Enter = 1'b0;
    if (op == 12) begin
      ifc.NumIn = W'($urandom_range(0, MASK));
      ifc.OpIn  = 4'($urandom_range(0, 15));
      if (pulse) begin
        @(negedge clock);
        ifc.OpIn  = 4'd0;
        ifc.NumIn = W'($urandom_range(1, MASK));
        ifc.Enter = 1'b1;
        @(negedge clock);
        ifc.Enter = 1'b0;
      end
      for (int i = 0; i < 4 * W && ifc.Busy; i++) @(negedge clock);
      check("busy_timeout", {31'd0, ifc.Busy}, 32'd0);
    end
  endtask

  // Monitor: detects accepted commands and pops/compares when the result shows.
  initial begin
    bit m_prev, m_busy, waiting, acc;
    int bcnt;
    logic [W-1:0] last_out, held;
    logic [W+1:0] e;
    m_prev = 1; m_busy = 0; waiting = 0; bcnt = 0; last_out = '0; held = '0;
    forever begin
      @(posedge clock);
      if (!Reset) begin
        m_prev = 1; m_busy = 0; waiting = 0; last_out = '0;
        continue;
      end
      acc = ifc.Enter && !m_prev && !m_busy;
      m_prev = ifc.Enter;
      #1;
      if (!Reset) continue;
      m_busy = ifc.Busy;
      if (acc && m_busy) begin
        waiting = 1; bcnt = 1; held = last_out;
        check("mul_hold", {24'd0, ifc.NumOut}, {24'd0, held});
      end else if (waiting && m_busy) begin
        bcnt++;
        check("mul_hold", {24'd0, ifc.NumOut}, {24'd0, held});
      end else if (acc || waiting) begin
        if (waiting) check("busy_cycles", bcnt, W);
        waiting = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got=%0h expected=none", ifc.NumOut);
        end else begin
          e = exp_q.pop_front();
          check("acc",   {24'd0, ifc.NumOut}, {24'd0, e[W-1:0]});
          check("carry", {31'd0, ifc.Carry},  {31'd0, e[W+1]});
          check("zero",  {31'd0, ifc.Zero},   {31'd0, e[W]});
        end
      end
      last_out = ifc.NumOut;
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus
  initial begin
    model_reset();
    ifc.Enter = 1'b1; ifc.OpIn = 4'd0; ifc.NumIn = 8'h33; ifc.RegSel = '0;
    repeat (2) @(negedge clock);
    check("rst_acc",   {24'd0, ifc.NumOut}, 32'd0);
    check("rst_carry", {31'd0, ifc.Carry},  32'd0);
    check("rst_zero",  {31'd0, ifc.Zero},   32'd1);
    check("rst_busy",  {31'd0, ifc.Busy},   32'd0);
    Reset = 1'b1;
    repeat (5) @(negedge clock);
    check("held_enter_acc",  {24'd0, ifc.NumOut}, 32'd0);
    check("held_enter_zero", {31'd0, ifc.Zero},   32'd1);
    ifc.Enter = 1'b0;
    cmd(0, 8'h00, 0, 0);
    cmd(8, 8'h05, 0, 0);

    cmd(8, 8'hF0, 0, 0);
    cmd(0, 8'h20, 0, 0);
    cmd(1, 8'h11, 0, 0);
    cmd(0, 8'h01, 0, 0);

    cmd(8, 8'h0C, 0, 0);
    cmd(12, 8'h0B, 0, 1);
    cmd(8, 8'h20, 0, 0);
    cmd(12, 8'h10, 0, 0);

    cmd(8, 8'h3C, 0, 0);
    cmd(9, 8'h00, 2, 0);
    cmd(11, 8'h00, 0, 0);
    cmd(10, 8'h00, 2, 0);
    cmd(10, 8'h00, 1, 0);

    // Reset asserted in the third busy cycle of a multiply.
    cmd(8, 8'h77, 0, 0);
    @(negedge clock);
    ifc.OpIn = 4'd12; ifc.NumIn = 8'hFF; ifc.Enter = 1'b1;
    @(negedge clock);
    ifc.Enter = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    Reset = 1'b0;
    #1;
    check("amul_rst_acc",   {24'd0, ifc.NumOut}, 32'd0);
    check("amul_rst_carry", {31'd0, ifc.Carry},  32'd0);
    check("amul_rst_zero",  {31'd0, ifc.Zero},   32'd1);
    check("amul_rst_busy",  {31'd0, ifc.Busy},   32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clock);
    Reset = 1'b1;
    @(negedge clock);
    check("post_rst_acc", {24'd0, ifc.NumOut}, 32'd0);
    cmd(0, 8'h09, 0, 0);
    cmd(10, 8'h00, 3, 0);

    cmd(8, 8'h07, 0, 0);
    cmd(4, 8'hFF, 0, 0);
    cmd(15, 8'h00, 0, 0);
    cmd(15, 8'h00, 0, 0);

    for (int k = 0; k < 150; k++) begin
      cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, MASK)),
          int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
